// File: rtl/nandy_regfile_pkg.sv
// Shared types and helpers for the stack-aware register file.
package nandy_regfile_pkg;

  // Controller states: IDLE accepts requests, the others finish two-cycle operations.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POP_WAIT = 2'd1,
    PAIR_HI  = 2'd2
  } state_e;

  // Winning request after arbitration, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_POP  = 3'd1,
    REQ_PUSH = 3'd2,
    REQ_PAIR = 3'd3,
    REQ_WR   = 3'd4
  } req_e;

  // Register-select width for a register count.
  function automatic int aw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stack_regfile_ctrl.sv
// Request arbitration, push/pop/pair sequencing, memory strobes and sticky errors.
// Produces two register write ports: a stack-pointer update and a general
// write; the general write is applied last so it wins on a collision.
module stack_regfile_ctrl
  import nandy_regfile_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                NREGS       = 4,
  parameter logic [WIDTH-1:0]  STACK_BASE  = '0,
  parameter logic [WIDTH-1:0]  STACK_LIMIT = WIDTH'(8'hF0),
  localparam int               AW          = aw_of(NREGS)
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               pop,
  input  logic               push,
  input  logic               pair_wr,
  input  logic               wr_en,
  input  logic [AW-1:0]      wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic [WIDTH-1:0]   push_data,
  input  logic [2*WIDTH-1:0] pair_data,
  input  logic               err_clr,
  input  logic [WIDTH-1:0]   sp_val,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [WIDTH-1:0]   mem_wd,
  output logic               busy,
  output logic               ov_err,
  output logic               un_err,
  output logic               rf_we,
  output logic [AW-1:0]      rf_sel,
  output logic [WIDTH-1:0]   rf_wdat,
  output logic               sp_we,
  output logic [WIDTH-1:0]   sp_wdat
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             ov_q, ov_d;
  logic             un_q, un_d;
  req_e             req;

  assign busy   = (state_q != IDLE);
  assign ov_err = ov_q;
  assign un_err = un_q;

  // Fixed-priority pick among simultaneous requests; losers are dropped.
  always_comb begin
    req = REQ_NONE;
    if (pop)          req = REQ_POP;
    else if (push)    req = REQ_PUSH;
    else if (pair_wr) req = REQ_PAIR;
    else if (wr_en)   req = REQ_WR;
  end

  // Next-state, memory strobes, register write controls and error flags.
  always_comb begin
    state_d  = state_q;
    wa_d     = wa_q;
    hi_d     = hi_q;
    ov_d     = ov_q & ~err_clr;
    un_d     = un_q & ~err_clr;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_wd   = '0;
    rf_we    = 1'b0;
    rf_sel   = '0;
    rf_wdat  = '0;
    sp_we    = 1'b0;
    sp_wdat  = '0;
    case (state_q)
      IDLE: begin
        case (req)
          REQ_POP: begin
            if (sp_val == STACK_BASE) begin
              un_d = 1'b1;
            end else begin
              mem_re   = 1'b1;
              mem_addr = sp_val;
              wa_d     = wa;
              state_d  = POP_WAIT;
            end
          end
          REQ_PUSH: begin
            if (sp_val == STACK_LIMIT) begin
              ov_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              mem_addr = sp_val - ONE;
              mem_wd   = push_data;
              sp_we    = 1'b1;
              sp_wdat  = sp_val - ONE;
            end
          end
          REQ_PAIR: begin
            rf_we   = 1'b1;
            rf_sel  = {wa[AW-1:1], 1'b0};
            rf_wdat = pair_data[WIDTH-1:0];
            hi_d    = pair_data[2*WIDTH-1:WIDTH];
            wa_d    = {wa[AW-1:1], 1'b1};
            state_d = PAIR_HI;
          end
          REQ_WR: begin
            rf_we   = 1'b1;
            rf_sel  = wa;
            rf_wdat = wd;
          end
          default: ;
        endcase
      end
      POP_WAIT: begin
        sp_we   = 1'b1;
        sp_wdat = sp_val + ONE;
        rf_we   = 1'b1;
        rf_sel  = wa_q;
        rf_wdat = mem_rdata;
        state_d = IDLE;
      end
      PAIR_HI: begin
        rf_we   = 1'b1;
        rf_sel  = wa_q;
        rf_wdat = hi_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
    end
  end

  // Latched destination and high half; only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    wa_q <= wa_d;
    hi_q <= hi_d;
  end

endmodule

// File: rtl/stack_regfile.sv
// Register file with a hardware stack pointer, two combinational read ports,
// push/pop to a synchronous stack memory and a two-cycle pair write.
module stack_regfile
  import nandy_regfile_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                NREGS       = 4,
  parameter int                SP_INDEX    = 1,
  parameter logic [WIDTH-1:0]  STACK_BASE  = '0,
  parameter logic [WIDTH-1:0]  STACK_LIMIT = WIDTH'(8'hF0),
  localparam int               AW          = aw_of(NREGS)
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic [AW-1:0]      rsA,
  input  logic [AW-1:0]      rsB,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic               wr_en,
  input  logic [AW-1:0]      wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  input  logic               pair_wr,
  input  logic [2*WIDTH-1:0] pair_data,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [WIDTH-1:0]   mem_wd,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               busy,
  output logic [WIDTH-1:0]   sp,
  output logic               ov_err,
  output logic               un_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             rf_we;
  logic [AW-1:0]    rf_sel;
  logic [WIDTH-1:0] rf_wdat;
  logic             sp_we;
  logic [WIDTH-1:0] sp_wdat;

  assign A  = regs_q[rsA];
  assign B  = regs_q[rsB];
  assign sp = regs_q[SP_INDEX];

  stack_regfile_ctrl #(
    .WIDTH       (WIDTH),
    .NREGS       (NREGS),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_ctrl (
    .clk       (clk),
    .nRST      (nRST),
    .pop       (pop),
    .push      (push),
    .pair_wr   (pair_wr),
    .wr_en     (wr_en),
    .wa        (wa),
    .wd        (wd),
    .push_data (push_data),
    .pair_data (pair_data),
    .err_clr   (err_clr),
    .sp_val    (regs_q[SP_INDEX]),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wd    (mem_wd),
    .busy      (busy),
    .ov_err    (ov_err),
    .un_err    (un_err),
    .rf_we     (rf_we),
    .rf_sel    (rf_sel),
    .rf_wdat   (rf_wdat),
    .sp_we     (sp_we),
    .sp_wdat   (sp_wdat)
  );

  // Merge SP update then general write, so a popped value landing in SP wins.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (sp_we) regs_d[SP_INDEX] = sp_wdat;
    if (rf_we) regs_d[rf_sel] = rf_wdat;
  end

  // Register array; reset clears everything and empties the stack.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? STACK_BASE : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule
